// File: rtl/hier_pkg.sv
// Shared widths and signature constants for the hierarchy capture stage.
package hier_pkg;
   localparam int HIER_W      = 3;
   localparam int HIER_FIFO_D = 4;
   localparam int SIG_W       = 8;
   localparam logic [SIG_W-1:0] SIG_MASK = 8'hB8;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_t;

   // One signature step: shift left with tap feedback, then fold in the word.
   function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] d);
      return {s[SIG_W-2:0], ^(s & SIG_MASK)} ^ d;
   endfunction
endpackage

// File: rtl/hier_fifo_mem.sv
// DEPTH x WIDTH register array, one write port and one asynchronous read port.
module hier_fifo_mem #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [DEPTH-1:0][WIDTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/hier_result_fifo.sv
// Result capture FIFO with sticky overflow flag.
// Define HIER_SIG_EN to add the running 8-bit signature port `sig`.
module hier_result_fifo
   import hier_pkg::*;
#(
   parameter int WIDTH = HIER_W,
   parameter int DEPTH = HIER_FIFO_D
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
`ifdef HIER_SIG_EN
   ,
   output logic [SIG_W-1:0]         sig
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic [WIDTH-1:0] rdata;
   logic             push, pop;
   occ_t             state;

   always_comb begin
      state = OCC_PARTIAL;
      if (count_q == '0)               state = OCC_EMPTY;
      else if (count_q == CW'(DEPTH))  state = OCC_FULL;
   end

   // Handshake flags come from registered occupancy only.
   assign in_ready  = (state != OCC_FULL);
   assign out_valid = (state != OCC_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? rdata : '0;
   assign count     = count_q;
   assign overflow  = overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (in_valid && !in_ready) overflow_q <= 1'b1;
      end
   end

   hier_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push & ~clr),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

`ifdef HIER_SIG_EN
   logic [SIG_W-1:0] sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sig_q <= '0;
      else if (clr)  sig_q <= '0;
      else if (push) sig_q <= sig_step(sig_q, SIG_W'(in_data));
   end

   assign sig = sig_q;
`endif
endmodule
